axi_aw_target_arbiter: RTL and testbench
========================================

Name: axi_aw_target_arbiter

Overview:
- Shares one target (slave-side) AW channel between N_INIT initiator-side address decoders.
- Each decoder presents its per-target awvalid; this block picks one request (round-robin), registers it, and forwards it to the target.
- Pushes the winner index into a W-routing FIFO so write data is steered in AW order.
- Back-pressures all requesters while the W-routing FIFO is full.

Parameters:
- N_INIT, 4, number of requesting initiator ports (>=2)
- ADDR_WIDTH, 32, AW address width
- ID_WIDTH, 4, incoming AWID width
- FIFO_DEPTH, 4, W-routing FIFO entries (power of 2, >=2)
- IDX_W, $clog2(N_INIT), winner index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_awvalid_i  in  N_INIT  per-initiator AW request toward this target
- req_awaddr_i  in  N_INIT*ADDR_WIDTH  packed addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_awid_i  in  N_INIT*ID_WIDTH  packed IDs, same packing
- req_awready_o  out  N_INIT  one-hot accept strobe to the winner
- awvalid_o  out  1  AW valid to target
- awaddr_o  out  ADDR_WIDTH  registered address
- awid_o  out  ID_WIDTH+IDX_W  {winner index, original ID}
- awready_i  in  1  target AW ready
- wsel_o  out  IDX_W  FIFO head: initiator owning the next W burst
- wsel_valid_o  out  1  FIFO not empty
- wsel_pop_i  in  1  pop head (W last beat handshake)
- fifo_full_o  out  1  W-routing FIFO full

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, FIFO count/pointers=0. Outputs: awvalid_o=0, req_awready_o=0, wsel_valid_o=0, fifo_full_o=0, awaddr_o=0, awid_o=0.
- Reset mid-transaction discards the held request and all FIFO contents. No target handshake completes in the reset cycle.
- FSM, 2 states:
  - IDLE: if |req_awvalid_i and count<FIFO_DEPTH:
    - winner w = first set bit searching from rr_ptr upward, wrapping.
    - req_awready_o[w]=1 combinationally this cycle; all other bits 0.
    - Capture awaddr/awid of w into output regs; store w.
    - Next state = BUSY.
    - Otherwise stay in IDLE; req_awready_o=0.
  - BUSY: awvalid_o=1; awaddr_o and awid_o stable.
    - req_awready_o=0; new requests are ignored.
    - On awready_i=1: push w into FIFO; rr_ptr = (w+1) mod N_INIT; next state = IDLE.
    - Otherwise hold.
- Latency: accept-to-awvalid_o = 1 cycle. Minimum 2 cycles per transaction.
- awvalid_o never deasserts before awready_i (AXI stability).
- FIFO:
  - Push only on the BUSY handshake; pop on wsel_pop_i when non-empty.
  - Pop when empty is ignored.
  - Simultaneous push and pop: count unchanged, head advances.
  - Pointers wrap modulo FIFO_DEPTH.
  - wsel_o is valid only while wsel_valid_o=1.
  - fifo_full_o = (count==FIFO_DEPTH).
- Full check is made at grant time in IDLE. The single held request cannot overflow the FIFO, because pops only decrease count.
- A request withdrawn by a requester before it is accepted is simply not granted. No state is changed.

Optional Feature:
- AW_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. rr_ptr is not implemented and reads as constant 0.
- Undefined (default): round-robin as described above.
- FSM, FIFO and handshake behaviour are identical in both builds.

Test Plan:
- Reset/idle: rst held 3 cycles, no requests -> all outputs 0; wsel_valid_o=0; no req_awready_o pulse.
- Single request: req_awvalid_i=4'b0100, addr 0x1000_0040, id 3, awready_i=1 -> same-cycle req_awready_o=4'b0100; next cycle awvalid_o=1, awaddr_o=0x1000_0040, awid_o={2'd2,4'd3}; then wsel_o=2, wsel_valid_o=1.
- Round-robin: all 4 requesting continuously, awready_i=1, no pops, FIFO_DEPTH=4 -> grant order 0,1,2,3; then fifo_full_o=1 and no 5th req_awready_o. With AW_ARB_FIXED_PRIO_EN: order 0,0,0,0.
- Target stall: awready_i=0 for 5 cycles in BUSY -> awvalid_o held at 1, address/ID unchanged, req_awready_o=0; handshake on cycle 6 -> one push.
- FIFO full + simultaneous: FIFO full, request pending, wsel_pop_i=1 -> next IDLE cycle grants. Push and pop in the same cycle -> count unchanged, wsel_o advances to the next entry.
- Reset mid-op: rst asserted in BUSY with 2 FIFO entries -> next cycle awvalid_o=0, wsel_valid_o=0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/axi_aw_target_arbiter.sv
// Shares one target AW channel among N_INIT initiators (round-robin) and records AW order in a W-routing FIFO.
// Define AW_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axi_aw_target_arbiter #(
   parameter int N_INIT     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int IDX_W      = $clog2(N_INIT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_INIT-1:0]            req_awvalid_i,
   input  logic [N_INIT*ADDR_WIDTH-1:0] req_awaddr_i,
   input  logic [N_INIT*ID_WIDTH-1:0]   req_awid_i,
   output logic [N_INIT-1:0]            req_awready_o,
   output logic                         awvalid_o,
   output logic [ADDR_WIDTH-1:0]        awaddr_o,
   output logic [ID_WIDTH+IDX_W-1:0]    awid_o,
   input  logic                         awready_i,
   output logic [IDX_W-1:0]             wsel_o,
   output logic                         wsel_valid_o,
   input  logic                         wsel_pop_i,
   output logic                         fifo_full_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INIT - 1);
   localparam logic [IDX_W:0]   NINIT_C  = (IDX_W+1)'(N_INIT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state, state_next;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        win, win_q;
   logic                    found;
   logic [IDX_W:0]          cand_sum;
   logic [IDX_W-1:0]        cand;
   logic [ADDR_WIDTH-1:0]   sel_addr, awaddr_q;
   logic [ID_WIDTH-1:0]     sel_id, awid_q;
   logic                    grant, push, pop;
   logic [IDX_W-1:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [CNT_W-1:0]        count;

   assign grant = (state == IDLE) && (|req_awvalid_i) && (count < DEPTH_C);
   assign push  = (state == BUSY) && awready_i;
   assign pop   = wsel_pop_i && (count != '0);

   // Search starts at rr_ptr and wraps; in the fixed-priority build rr_ptr is tied to 0.
   always_comb begin
      win      = '0;
      found    = 1'b0;
      cand_sum = '0;
      cand     = '0;
      for (int i = 0; i < N_INIT; i++) begin
         cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (cand_sum >= NINIT_C)
            cand_sum = cand_sum - NINIT_C;
         cand = cand_sum[IDX_W-1:0];
         if (!found && req_awvalid_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_id   = '0;
      for (int k = 0; k < N_INIT; k++) begin
         if (win == IDX_W'(k)) begin
            sel_addr = req_awaddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_id   = req_awid_i[k*ID_WIDTH +: ID_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant) state_next = BUSY;
         BUSY:    if (awready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_awready_o = '0;
      awvalid_o     = (state == BUSY);
      if (grant)
         req_awready_o[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         awaddr_q <= '0;
         awid_q   <= '0;
         win_q    <= '0;
      end else if (grant) begin
         awaddr_q <= sel_addr;
         awid_q   <= sel_id;
         win_q    <= win;
      end
   end

`ifdef AW_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   // The initiator after the last one to complete its AW handshake gets first look.
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (push)
         rr_ptr <= (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset; only the count decides what is valid.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= win_q;
   end

   assign awaddr_o     = awaddr_q;
   assign awid_o       = {win_q, awid_q};
   assign wsel_o       = fifo_mem[rd_ptr];
   assign wsel_valid_o = (count != '0);
   assign fifo_full_o  = (count == DEPTH_C);

endmodule

// File: tb/tb_axi_aw_target_arbiter.sv
// Self-checking bench for axi_aw_target_arbiter: queue-based reference model plus directed literal checks.
// Honours AW_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_axi_aw_target_arbiter;

   localparam int N_INIT     = 4;
   localparam int ADDR_WIDTH = 32;
   localparam int ID_WIDTH   = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int IDX_W      = 2;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [N_INIT-1:0]            req_valid;
   logic [N_INIT*ADDR_WIDTH-1:0] req_awaddr;
   logic [N_INIT*ID_WIDTH-1:0]   req_awid;
   logic [N_INIT-1:0]            req_awready;
   logic                         awvalid;
   logic [ADDR_WIDTH-1:0]        awaddr;
   logic [ID_WIDTH+IDX_W-1:0]    awid;
   logic                         awready;
   logic [IDX_W-1:0]             wsel;
   logic                         wsel_valid;
   logic                         wsel_pop;
   logic                         fifo_full;

   logic [ADDR_WIDTH-1:0] addr_arr [N_INIT];
   logic [ID_WIDTH-1:0]   id_arr   [N_INIT];

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   // Reference model state
   logic                  m_busy = 1'b0;
   int                    m_win  = 0;
   int                    m_rr   = 0;
   logic [ADDR_WIDTH-1:0] m_addr = '0;
   logic [ID_WIDTH-1:0]   m_id   = '0;
   int                    m_fifo [$];

`ifdef AW_ARB_FIXED_PRIO_EN
   localparam int RR_EXP [4] = '{0, 0, 0, 0};
   localparam int SIM_HEAD0 = 0;
   localparam int SIM_HEAD1 = 0;
`else
   localparam int RR_EXP [4] = '{0, 1, 2, 3};
   localparam int SIM_HEAD0 = 1;
   localparam int SIM_HEAD1 = 2;
`endif

   axi_aw_target_arbiter #(
      .N_INIT(N_INIT), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .req_awvalid_i(req_valid), .req_awaddr_i(req_awaddr), .req_awid_i(req_awid),
      .req_awready_o(req_awready),
      .awvalid_o(awvalid), .awaddr_o(awaddr), .awid_o(awid), .awready_i(awready),
      .wsel_o(wsel), .wsel_valid_o(wsel_valid), .wsel_pop_i(wsel_pop),
      .fifo_full_o(fifo_full)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_awaddr = '0;
      req_awid   = '0;
      for (int k = 0; k < N_INIT; k++) begin
         req_awaddr[k*ADDR_WIDTH +: ADDR_WIDTH] = addr_arr[k];
         req_awid[k*ID_WIDTH +: ID_WIDTH]       = id_arr[k];
      end
   end

   // Winner the arbitration rules demand this cycle, -1 when nothing may be granted.
   function automatic int exp_winner();
      if (m_busy || m_fifo.size() >= FIFO_DEPTH || req_valid == '0)
         return -1;
      for (int i = 0; i < N_INIT; i++) begin
`ifdef AW_ARB_FIXED_PRIO_EN
         if (req_valid[i]) return i;
`else
         if (req_valid[(m_rr + i) % N_INIT]) return (m_rr + i) % N_INIT;
`endif
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [N_INIT-1:0] v,
                                input logic rdy, input logic p);
      @(posedge clk);
      #1;
      rst       = r;
      req_valid = v;
      awready   = rdy;
      wsel_pop  = p;
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      int w;
      if (rst) begin
         m_busy = 1'b0;
         m_rr   = 0;
         m_fifo.delete();
      end else begin
         w = exp_winner();
         if (wsel_pop && m_fifo.size() > 0)
            void'(m_fifo.pop_front());
         if (m_busy && awready) begin
            m_fifo.push_back(m_win);
            m_rr   = (m_win + 1) % N_INIT;
            m_busy = 1'b0;
         end else if (w >= 0) begin
            m_busy = 1'b1;
            m_win  = w;
            m_addr = addr_arr[w];
            m_id   = id_arr[w];
         end
      end
   end

   always @(negedge clk) begin
      int w;
      logic [N_INIT-1:0] exp_rdy;
      if (chk_en && !rst) begin
         w = exp_winner();
         exp_rdy = (w < 0) ? '0 : (N_INIT'(1) << w);
         checkOutput("m_req_awready", 64'(req_awready), 64'(exp_rdy));
         checkOutput("m_awvalid", 64'(awvalid), 64'(m_busy));
         if (m_busy) begin
            checkOutput("m_awaddr", 64'(awaddr), 64'(m_addr));
            checkOutput("m_awid", 64'(awid), 64'({IDX_W'(m_win), m_id}));
         end
         checkOutput("m_wsel_valid", 64'(wsel_valid), 64'(m_fifo.size() > 0));
         if (m_fifo.size() > 0)
            checkOutput("m_wsel", 64'(wsel), 64'(m_fifo[0]));
         checkOutput("m_fifo_full", 64'(fifo_full), 64'(m_fifo.size() == FIFO_DEPTH));
      end
   end

   initial begin
      int grant_log [$];
      logic [5:0] vec [16];
      addr_arr = '{32'hA000_0010, 32'hB000_0020, 32'h1000_0040, 32'hC000_0030};
      id_arr   = '{4'h9, 4'h5, 4'h3, 4'hE};
      // {req[3:0], awready, pop}
      vec = '{6'b1000_0_0, 6'b0000_0_0, 6'b0110_0_0, 6'b0110_1_0,
              6'b0001_1_0, 6'b0000_1_1, 6'b0011_1_1, 6'b1100_1_0,
              6'b1111_0_1, 6'b1111_1_0, 6'b0101_1_1, 6'b0000_1_1,
              6'b1010_1_0, 6'b1010_1_1, 6'b0000_0_1, 6'b0000_0_1};
      rst = 1'b1; req_valid = '0; awready = 1'b0; wsel_pop = 1'b0;

      repeat (3) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      chk_en = 1'b1;

      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput("reset_awvalid", 64'(awvalid), 64'(0));
      checkOutput("reset_req_awready", 64'(req_awready), 64'(0));
      checkOutput("reset_wsel_valid", 64'(wsel_valid), 64'(0));
      checkOutput("reset_fifo_full", 64'(fifo_full), 64'(0));
      checkOutput("reset_awaddr", 64'(awaddr), 64'(0));
      checkOutput("reset_awid", 64'(awid), 64'(0));

      applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
      checkOutput("single_grant", 64'(req_awready), 64'(4'b0100));
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      checkOutput("single_awvalid", 64'(awvalid), 64'(1));
      checkOutput("single_awaddr", 64'(awaddr), 64'(32'h1000_0040));
      checkOutput("single_awid", 64'(awid), 64'(6'h23));
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      checkOutput("single_wsel_valid", 64'(wsel_valid), 64'(1));
      checkOutput("single_wsel", 64'(wsel), 64'(2));
      checkOutput("single_awvalid_drop", 64'(awvalid), 64'(0));
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);

      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
         for (int k = 0; k < N_INIT; k++)
            if (req_awready[k]) grant_log.push_back(k);
      end
      checkOutput("rr_grant_count", 64'(grant_log.size()), 64'(4));
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         checkOutput("rr_order", 64'(grant_log[i]), 64'(RR_EXP[i]));
      checkOutput("rr_fifo_full", 64'(fifo_full), 64'(1));

      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      checkOutput("full_no_grant", 64'(req_awready), 64'(0));
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
      checkOutput("after_pop_grant", 64'(req_awready), 64'(4'b0001));
      checkOutput("after_pop_not_full", 64'(fifo_full), 64'(0));
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      checkOutput("sim_head_before", 64'(wsel), 64'(SIM_HEAD0));
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      checkOutput("sim_head_after", 64'(wsel), 64'(SIM_HEAD1));
      checkOutput("sim_count_kept", 64'(fifo_full), 64'(0));

      repeat (4) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput("drained_empty", 64'(wsel_valid), 64'(0));

      applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
      checkOutput("stall_grant", 64'(req_awready), 64'(4'b0010));
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
         checkOutput("stall_awvalid", 64'(awvalid), 64'(1));
         checkOutput("stall_awaddr", 64'(awaddr), 64'(32'hB000_0020));
         checkOutput("stall_awid", 64'(awid), 64'(6'h15));
         checkOutput("stall_no_grant", 64'(req_awready), 64'(0));
      end
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput("stall_push_head", 64'(wsel), 64'(1));
      checkOutput("stall_push_valid", 64'(wsel_valid), 64'(1));
      checkOutput("stall_done", 64'(awvalid), 64'(0));

      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      repeat (4) applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput("midop_busy", 64'(awvalid), 64'(1));
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
      checkOutput("midop_awvalid", 64'(awvalid), 64'(0));
      checkOutput("midop_wsel_valid", 64'(wsel_valid), 64'(0));
      checkOutput("midop_rr_reset", 64'(req_awready), 64'(4'b0001));

      for (int i = 0; i < 16; i++) begin
         logic [5:0] v;
         v = vec[i];
         applyStimulus(1'b0, v[5:2], v[1], v[0]);
      end

      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
